// File: rtl/design_switch_sequencer_pkg.sv
// Shared types for the design-select sequencer: select width, default design
// count and the switch FSM state encoding.
package stars_select_pkg;

  localparam int NUM_DESIGNS = 12;

  typedef logic [3:0] sel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SWITCH,
    ST_RESET_HOLD,
    ST_RELEASE
  } switch_state_t;

endpackage

// File: rtl/design_switch_sequencer_if.sv
// Request handshake and mux-control bundle between the host logic, the
// switch sequencer and the design mux.
interface design_switch_sequencer_if;
  import stars_select_pkg::*;

  logic req_valid;
  sel_t req_sel;
  logic req_ready;
  sel_t design_select;
  logic out_gate;
  logic design_hold_n;
  logic busy;
  logic done;
  logic err_invalid;

  modport master (
    output req_valid, req_sel,
    input  req_ready, design_select, out_gate, design_hold_n, busy, done,
           err_invalid
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, design_select, out_gate, design_hold_n, busy, done,
           err_invalid
  );

endinterface

// File: rtl/design_switch_sequencer_cycle_timer.sv
// Loadable interval timer: start_i clears it and loads count_i; expired_o is
// high for one cycle on the count_i-th cycle after start.
module cycle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             run_q, run_d;

  assign expired_o = run_q && (cnt_q == last_q);

  // Counts up to last and then stops, so the counter never wraps.
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    run_d  = run_q;
    if (start_i) begin
      cnt_d  = '0;
      last_d = count_i - WIDTH'(1);
      run_d  = 1'b1;
    end else if (run_q) begin
      if (expired_o) run_d = 1'b0;
      else           cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      last_q <= '0;
      run_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: rtl/design_switch_sequencer.sv
// Owns design_select for the design mux: gates GPIOs, drains, commits the new
// select, holds the new design in reset and then releases it.
module design_switch_sequencer #(
  parameter int NUM_DESIGNS  = stars_select_pkg::NUM_DESIGNS,
  parameter int GUARD_CYCLES = 4,
  parameter int RESET_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        n_rst,
  design_switch_sequencer_if.slave    bus
);
  import stars_select_pkg::sel_t, stars_select_pkg::switch_state_t;
  import stars_select_pkg::ST_IDLE, stars_select_pkg::ST_DRAIN;
  import stars_select_pkg::ST_SWITCH, stars_select_pkg::ST_RESET_HOLD;
  import stars_select_pkg::ST_RELEASE;

  localparam int   MAX_CYCLES = (GUARD_CYCLES > RESET_CYCLES) ? GUARD_CYCLES : RESET_CYCLES;
  localparam int   CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam sel_t MAX_SEL    = sel_t'(NUM_DESIGNS);

  switch_state_t state_q, state_d;
  sel_t          pending_q, pending_d;
  sel_t          sel_q, sel_d;
  logic          gate_q, gate_d;
  logic          hold_n_q, hold_n_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic             tmr_start;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_expired;

  cycle_timer #(.WIDTH(CNT_W)) u_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .start_i   (tmr_start),
    .count_i   (tmr_count),
    .expired_o (tmr_expired)
  );

  // NOTE: every _d gets its default first; a branch that forgets to assign one would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    sel_d     = sel_q;
    gate_d    = gate_q;
    hold_n_d  = hold_n_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tmr_start = 1'b0;
    tmr_count = CNT_W'(GUARD_CYCLES);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_sel > MAX_SEL) begin
            err_d = 1'b1;
          end else if (bus.req_sel == sel_q) begin
            done_d = 1'b1;
          end else begin
            pending_d = bus.req_sel;
            gate_d    = 1'b1;
            tmr_start = 1'b1;
            state_d   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // The old design goes into reset before the select ever moves.
        if (tmr_expired) begin
          hold_n_d = 1'b0;
          state_d  = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        sel_d    = pending_q;
        hold_n_d = 1'b0;
        if (pending_q == '0) begin
          state_d = ST_RELEASE;
        end else begin
          tmr_start = 1'b1;
          tmr_count = CNT_W'(RESET_CYCLES);
          state_d   = ST_RESET_HOLD;
        end
      end
      ST_RESET_HOLD: begin
        if (tmr_expired) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        hold_n_d = (sel_q != '0);
        gate_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: pending_sel is reset along with the outputs so an aborted request can never resurface.
      state_q   <= ST_IDLE;
      pending_q <= '0;
      sel_q     <= '0;
      gate_q    <= 1'b0;
      hold_n_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      gate_q    <= gate_d;
      hold_n_q  <= hold_n_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready     = (state_q == ST_IDLE);
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.design_select = sel_q;
  assign bus.out_gate      = gate_q;
  assign bus.design_hold_n = hold_n_q;
  assign bus.done          = done_q;
  assign bus.err_invalid   = err_q;

endmodule
